// File: rtl/borrow_lookahead_subtractor_pipe_pkg.sv
// Shared types and the 4-bit borrow-lookahead equations
// used by both stages of the pipelined 8-bit subtractor.
package subtract_pkg;

  localparam int WIDTH  = 8;
  localparam int NIBBLE = 4;

  typedef logic [NIBBLE-1:0] nib_t;

  typedef struct packed {
    nib_t diff_lo;
    logic br4;
    nib_t a_hi;
    nib_t b_hi;
    logic sx;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;
  } s2_t;

  // br[3:0] are the borrows into bits 0..3, br[4] is the borrow-out.
  // Every term is flattened so no borrow ripples through a chain.
  function automatic logic [4:0] borrow_la4(
    nib_t p,
    nib_t g,
    logic bin
  );
    logic [4:0] br;
    br[0] = bin;
    br[1] = g[0] | (p[0] & bin);
    br[2] = g[1] | (p[1] & g[0])
          | (p[1] & p[0] & bin);
    br[3] = g[2] | (p[2] & g[1])
          | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & bin);
    br[4] = g[3] | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bin);
    return br;
  endfunction

endpackage

// File: rtl/borrow_lookahead_subtractor_pipe_if.sv
// Operand/result handshake bundle of the subtractor.
// master drives operands + out_ready; slave is the subtractor.
interface borrow_lookahead_subtractor_pipe_if;
  import subtract_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff,
    input  bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff,
    output bout, ovf, zero
  );
endinterface

// File: rtl/borrow_lookahead_subtractor_pipe_nibble.sv
// 4-bit combinational borrow-lookahead subtractor slice.
// Ports: a, b, bin in; diff, bout out (diff = a - b - bin).
module nibble_borrow_lookahead
  import subtract_pkg::*;
(
  input  nib_t a,
  input  nib_t b,
  input  logic bin,
  output nib_t diff,
  output logic bout
);

  nib_t       p;
  nib_t       g;
  logic [4:0] br;

  assign p    = ~(a ^ b);
  assign g    = ~a & b;
  assign br   = borrow_la4(p, g, bin);
  assign diff = a ^ b ^ br[3:0];
  assign bout = br[4];

endmodule

// File: rtl/borrow_lookahead_subtractor_pipe.sv
// Two-stage 8-bit a - b - bin: low nibble in stage 1, high in stage 2.
// Ports: clk, rst (async high), io (slave handshake bundle).
module borrow_lookahead_subtractor_pipe
  import subtract_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  borrow_lookahead_subtractor_pipe_if.slave  io
);

  logic s1_valid;
  logic s2_valid;
  s1_t  s1;
  s2_t  s2;

  logic accept;
  logic s2_adv;
  nib_t lo_diff;
  logic lo_bout;
  nib_t hi_diff;
  logic hi_bout;

  assign s2_adv = s1_valid
                & (~s2_valid | io.out_ready);
  assign io.in_ready = ~s1_valid | s2_adv;
  assign accept = io.in_valid & io.in_ready;

  assign io.out_valid = s2_valid;
  assign io.diff      = s2.diff;
  assign io.bout      = s2.bout;
  assign io.ovf       = s2.ovf;
  assign io.zero      = s2.zero;

  nibble_borrow_lookahead u_lo (
    .a    (io.a[3:0]),
    .b    (io.b[3:0]),
    .bin  (io.bin),
    .diff (lo_diff),
    .bout (lo_bout)
  );

  nibble_borrow_lookahead u_hi (
    .a    (s1.a_hi),
    .b    (s1.b_hi),
    .bin  (s1.br4),
    .diff (hi_diff),
    .bout (hi_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1.diff_lo <= lo_diff;
      s1.br4     <= lo_bout;
      s1.a_hi    <= io.a[7:4];
      s1.b_hi    <= io.b[7:4];
      s1.sx      <= io.a[7] ^ io.b[7];
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Signed overflow only when operand signs differ and the
  // result sign departs from the minuend's sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2.diff  <= {hi_diff, s1.diff_lo};
      s2.bout  <= hi_bout;
      s2.ovf   <= s1.sx
                & (s1.a_hi[3] ^ hi_diff[3]);
      s2.zero  <= (hi_diff == '0)
                & (s1.diff_lo == '0);
    end else if (io.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_borrow_lookahead_subtractor_pipe.sv
// Scoreboard bench: directed cases, stall, reset, random.
// Expected results come from plain integer arithmetic.
module tb_borrow_lookahead_subtractor_pipe;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [10:0] sb[$];
  logic        hold_prev;
  logic [10:0] hold_val;

  borrow_lookahead_subtractor_pipe_if io ();

  borrow_lookahead_subtractor_pipe dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(
    string nm,
    logic [31:0] act,
    logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  // {bout, ovf, zero, diff}
  function automatic logic [10:0] model(
    logic [7:0] a,
    logic [7:0] b,
    logic       bin
  );
    int u;
    int s;
    logic [7:0] d;
    logic bo;
    logic ov;
    u  = int'(a) - int'(b) - int'(bin);
    s  = int'($signed(a)) - int'($signed(b))
       - int'(bin);
    d  = u[7:0];
    bo = (u < 0);
    ov = (s < -128) || (s > 127);
    return {bo, ov, (d == 8'h00), d};
  endfunction

  function automatic logic [10:0] res();
    return {io.bout, io.ovf, io.zero, io.diff};
  endfunction

  always @(negedge clk) begin
    if (!rst && io.in_valid && io.in_ready)
      sb.push_back(model(io.a, io.b, io.bin));
  end

  always @(negedge clk) begin
    if (!rst && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(res()), 32'h7ff);
      end else begin
        check("result", 32'(res()),
              32'(sb.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && hold_prev)
      check("hold", 32'({io.out_valid, res()}),
            32'({1'b1, hold_val}));
    hold_prev = !rst && io.out_valid
              && !io.out_ready;
    hold_val  = res();
  end

  task automatic idle();
    io.in_valid = 1'b0;
  endtask

  task automatic send(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       bin
  );
    int  n;
    logic ok;
    n = 0;
    io.a = a;
    io.b = b;
    io.bin = bin;
    io.in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = io.in_ready;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("send_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((sb.size() != 0 || io.out_valid)
           && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 32'(n < 1000), 32'(1));
  endtask

  initial begin
    int acc;
    int sent;
    int cyc;
    logic took;
    n_chk = 0;
    n_fail = 0;
    hold_prev = 1'b0;
    hold_val = '0;
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.bin = 1'b0;
    io.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(io.in_ready), 32'(1));
    check("rst_out_valid", 32'(io.out_valid), 32'(0));
    check("rst_res", 32'(res()), 32'(0));
    rst = 1'b0;

    // directed cases and latency
    io.out_ready = 1'b1;
    send(8'h50, 8'h20, 1'b0);
    idle();
    @(negedge clk);
    check("lat_early", 32'(io.out_valid), 32'(0));
    @(negedge clk);
    check("lat", 32'(io.out_valid), 32'(1));
    check("d_50_20", 32'(res()), 32'(11'h030));
    @(posedge clk);
    #1;
    send(8'h00, 8'h01, 1'b0);
    send(8'h80, 8'h01, 1'b0);
    send(8'h10, 8'h0f, 1'b1);
    send(8'h7f, 8'hff, 1'b0);
    idle();
    wait_empty();

    // stall: 6 beats a=i, out_ready low for 5 cycles
    io.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      io.a = 8'(acc);
      io.b = 8'h00;
      io.bin = 1'b0;
      io.in_valid = 1'b1;
      @(negedge clk);
      if (io.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    check("stall_acc", 32'(acc), 32'(2));
    check("stall_rdy", 32'(io.in_ready), 32'(0));
    check("stall_ov", 32'(io.out_valid), 32'(1));
    io.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (acc < 6) begin
        io.a = 8'(acc);
        io.in_valid = 1'b1;
      end else begin
        io.in_valid = 1'b0;
      end
      @(negedge clk);
      check("no_gap", 32'(io.out_valid), 32'(1));
      if (io.in_valid && io.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    idle();
    check("stall_total", 32'(acc), 32'(6));
    wait_empty();

    // reset with two beats in flight
    io.out_ready = 1'b0;
    send(8'h33, 8'h11, 1'b0);
    send(8'h44, 8'h11, 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(io.out_valid), 32'(0));
    check("arst_in_ready", 32'(io.in_ready), 32'(1));
    check("arst_res", 32'(res()), 32'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    io.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_stale", 32'(io.out_valid), 32'(0));
    end
    @(posedge clk);
    #1;

    // random traffic
    sent = 0;
    cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      if (!io.in_valid && $urandom_range(3) != 0) begin
        io.a = 8'($urandom);
        io.b = 8'($urandom);
        io.bin = 1'($urandom);
        io.in_valid = 1'b1;
      end
      io.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      took = io.in_valid && io.in_ready;
      if (took) sent++;
      @(posedge clk);
      #1;
      if (took) io.in_valid = 1'b0;
      cyc++;
    end
    check("rand_sent", 32'(sent), 32'(10000));
    idle();
    io.out_ready = 1'b1;
    wait_empty();
    check("sb_empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
